// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble sequencer for the IF_ID, ID_EX and
// EX_MEM registers and the PC, with precise exception entry (EPC + cause).
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter logic [31:0] HANDLER_PC   = 32'h0000_0080,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  id_rs1,
    input  logic [2:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_mem_read,
    input  logic [2:0]  ex_rd_load,
    input  logic        ex_invalid,
    input  logic        ex_cause,
    input  logic [31:0] ex_pc,
    input  logic        mem_busy,
    input  logic [31:0] mem_pc,
    output logic        pc_write,
    output logic        if_write,
    output logic        id_write,
    output logic        exmem_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        pc_sel,
    output logic [31:0] handler_pc,
    output logic [31:0] epc,
    output logic [1:0]  cause_reg,
    output logic        exc_active
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] wait_cnt,
    output logic [7:0]  exc_cnt
`endif
);

    localparam int unsigned TimeoutW = 8;
    localparam int unsigned FlushW   = 4;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        MEM_WAIT     = 2'd1,
        EXC_FLUSH    = 2'd2,
        EXC_REDIRECT = 2'd3
    } stateT;

    stateT               stateQ;
    stateT               nextState;
    logic [TimeoutW-1:0] timeoutCnt;
    logic [FlushW-1:0]   flushCnt;
    logic                memExc;
    logic                exExc;
    logic                loadUse;
    logic                runLike;
    logic                timeoutHit;
    logic                flushDone;

    assign handler_pc = HANDLER_PC;

    // Hazard and counter-terminal decodes shared by the FSM and datapath
    assign loadUse    = ex_mem_read &
                        ((id_use_rs1 & (id_rs1 == ex_rd_load)) |
                         (id_use_rs2 & (id_rs2 == ex_rd_load)));
    assign runLike    = (stateQ == RUN) || (stateQ == MEM_WAIT);
    assign timeoutHit = (timeoutCnt == TimeoutW'(MEM_TIMEOUT - 1));
    assign flushDone  = (flushCnt == FlushW'(FLUSH_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= RUN;
        end else begin
            stateQ <= nextState;
        end
    end

    // Next-state logic; MEM_WAIT with memory ready behaves exactly like RUN
    always_comb begin
        nextState = stateQ;
        memExc    = 1'b0;
        exExc     = 1'b0;
        case (stateQ)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    if (timeoutHit) begin
                        memExc    = 1'b1;
                        nextState = EXC_FLUSH;
                    end else begin
                        nextState = MEM_WAIT;
                    end
                end else if (ex_invalid) begin
                    exExc     = 1'b1;
                    nextState = EXC_FLUSH;
                end else begin
                    nextState = RUN;
                end
            end
            EXC_FLUSH: begin
                if (flushDone) begin
                    nextState = EXC_REDIRECT;
                end
            end
            EXC_REDIRECT: nextState = RUN;
            default:      nextState = RUN;
        endcase
    end

    // Pipeline control outputs, all forced low while reset is asserted
    always_comb begin
        pc_write     = 1'b0;
        if_write     = 1'b0;
        id_write     = 1'b0;
        exmem_write  = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        pc_sel       = 1'b0;
        exc_active   = 1'b0;
        if (reset) begin
            case (stateQ)
                RUN, MEM_WAIT: begin
                    if (mem_busy) begin
                        pc_write = 1'b0;
                    end else if (ex_invalid) begin
                        id_write     = 1'b1;
                        exmem_write  = 1'b1;
                        ifid_flush   = 1'b1;
                        idex_bubble  = 1'b1;
                        exmem_bubble = 1'b1;
                    end else if (loadUse) begin
                        id_write    = 1'b1;
                        exmem_write = 1'b1;
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_write    = 1'b1;
                        id_write    = 1'b1;
                        exmem_write = 1'b1;
                    end
                end
                EXC_FLUSH: begin
                    id_write     = 1'b1;
                    exmem_write  = 1'b1;
                    ifid_flush   = 1'b1;
                    idex_bubble  = 1'b1;
                    exmem_bubble = 1'b1;
                    exc_active   = 1'b1;
                end
                EXC_REDIRECT: begin
                    pc_write    = 1'b1;
                    if_write    = 1'b1;
                    id_write    = 1'b1;
                    exmem_write = 1'b1;
                    ifid_flush  = 1'b1;
                    pc_sel      = 1'b1;
                    exc_active  = 1'b1;
                end
                default: pc_write = 1'b0;
            endcase
        end
    end

    // Timeout/flush counters and exception capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeoutCnt <= '0;
            flushCnt   <= '0;
            epc        <= '0;
            cause_reg  <= 2'b00;
        end else begin
            timeoutCnt <= (runLike && mem_busy && !timeoutHit) ?
                          timeoutCnt + TimeoutW'(1) : '0;
            flushCnt   <= (stateQ == EXC_FLUSH && !flushDone) ?
                          flushCnt + FlushW'(1) : '0;
            if (memExc) begin
                epc       <= mem_pc;
                cause_reg <= 2'b10;
            end else if (exExc) begin
                epc       <= ex_pc;
                cause_reg <= {ex_cause, 1'b1};
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic stallNow;
    logic excEntry;

    assign stallNow = runLike & ~mem_busy & ~ex_invalid & loadUse;
    assign excEntry = memExc | exExc;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            wait_cnt  <= '0;
            exc_cnt   <= '0;
        end else begin
            if (stallNow && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (stateQ == MEM_WAIT && wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (excEntry && exc_cnt != 8'hFF) begin
                exc_cnt <= exc_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle pushes its
// expected controls, EPC and cause; a monitor pops and compares before the
// following rising edge.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  id_rs1;
    logic [2:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        ex_mem_read;
    logic [2:0]  ex_rd_load;
    logic        ex_invalid;
    logic        ex_cause;
    logic [31:0] ex_pc;
    logic        mem_busy;
    logic [31:0] mem_pc;
    logic        pc_write;
    logic        if_write;
    logic        id_write;
    logic        exmem_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_bubble;
    logic        pc_sel;
    logic [31:0] handler_pc;
    logic [31:0] epc;
    logic [1:0]  cause_reg;
    logic        exc_active;

    pipeline_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_mem_read  (ex_mem_read),
        .ex_rd_load   (ex_rd_load),
        .ex_invalid   (ex_invalid),
        .ex_cause     (ex_cause),
        .ex_pc        (ex_pc),
        .mem_busy     (mem_busy),
        .mem_pc       (mem_pc),
        .pc_write     (pc_write),
        .if_write     (if_write),
        .id_write     (id_write),
        .exmem_write  (exmem_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .exmem_bubble (exmem_bubble),
        .pc_sel       (pc_sel),
        .handler_pc   (handler_pc),
        .epc          (epc),
        .cause_reg    (cause_reg),
        .exc_active   (exc_active)
    );

    // Control vector order: pc_write if_write id_write exmem_write
    //                       ifid_flush idex_bubble exmem_bubble pc_sel exc_active
    localparam logic [8:0] ALL        = 9'b1111_111_11;
    localparam logic [8:0] NORMAL     = 9'b1111_000_00;
    localparam logic [8:0] LOADUSE    = 9'b0011_010_00;
    localparam logic [8:0] BUSY       = 9'b0000_000_00;
    localparam logic [8:0] INVALID    = 9'b0000_111_00;
    localparam logic [8:0] INVALID_M  = 9'b1000_111_11;
    localparam logic [8:0] FLUSH      = 9'b0001_111_01;
    localparam logic [8:0] FLUSH_M    = 9'b1101_111_11;
    localparam logic [8:0] REDIRECT   = 9'b1000_100_11;
    localparam logic [8:0] REDIRECT_M = 9'b1000_100_11;
    localparam logic [8:0] RESET_V    = 9'b0000_000_00;

    typedef struct {
        string       tag;
        logic [8:0]  ctl;
        logic [8:0]  mask;
        logic [31:0] epcV;
        logic [1:0]  causeV;
    } expT;

    expT expQ[$];
    int  nChecks = 0;
    int  nFails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [8:0] ctl, input logic [8:0] mask,
                           input logic [31:0] epcV, input logic [1:0] causeV);
        expT e;
        e.tag    = tag;
        e.ctl    = ctl;
        e.mask   = mask;
        e.epcV   = epcV;
        e.causeV = causeV;
        expQ.push_back(e);
    endtask

    task automatic idleInputs();
        id_rs1      = 3'd0;
        id_rs2      = 3'd0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd_load  = 3'd0;
        ex_invalid  = 1'b0;
        ex_cause    = 1'b0;
        ex_pc       = 32'h0000_0000;
        mem_busy    = 1'b0;
        mem_pc      = 32'h0000_0000;
    endtask

    // Monitor: compare the oldest expectation one time unit before the rising edge
    initial begin
        expT        e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            #4;
            if (expQ.size() != 0) begin
                e   = expQ.pop_front();
                got = {pc_write, if_write, id_write, exmem_write,
                       ifid_flush, idex_bubble, exmem_bubble, pc_sel, exc_active};
                checkVal({e.tag, ".ctl"}, 32'(got & e.mask), 32'(e.ctl & e.mask));
                checkVal({e.tag, ".epc"}, epc, e.epcV);
                checkVal({e.tag, ".cause"}, 32'(cause_reg), 32'(e.causeV));
            end
        end
    end

    // Stimulus
    initial begin
        reset = 1'b1;
        idleInputs();
        #2 reset = 1'b0;

        @(negedge clk); pushExp("reset", RESET_V, ALL, 32'h0, 2'b00);
        @(negedge clk); reset = 1'b1; pushExp("run", NORMAL, ALL, 32'h0, 2'b00);

        // Load-use on rs2, then release
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd_load = 3'd3; id_rs2 = 3'd3; id_use_rs2 = 1'b1;
        pushExp("luRs2", LOADUSE, ALL, 32'h0, 2'b00);
        @(negedge clk); idleInputs(); pushExp("luAfter", NORMAL, ALL, 32'h0, 2'b00);

        // Matching but unused source: no stall
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd_load = 3'd3; id_rs2 = 3'd3; id_use_rs2 = 1'b0;
        pushExp("luUnused", NORMAL, ALL, 32'h0, 2'b00);

        // Load-use on rs1
        @(negedge clk);
        idleInputs(); ex_mem_read = 1'b1; ex_rd_load = 3'd5; id_rs1 = 3'd5; id_use_rs1 = 1'b1;
        pushExp("luRs1", LOADUSE, ALL, 32'h0, 2'b00);

        // Match without a load in EX: no stall
        @(negedge clk); ex_mem_read = 1'b0; pushExp("noLoad", NORMAL, ALL, 32'h0, 2'b00);

        // Memory wait of 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idleInputs(); mem_busy = 1'b1;
            pushExp($sformatf("wait%0d", i), BUSY, ALL, 32'h0, 2'b00);
        end
        @(negedge clk); idleInputs(); pushExp("waitEnd", NORMAL, ALL, 32'h0, 2'b00);

        // 15 busy cycles: one short of the timeout
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); mem_busy = 1'b1; mem_pc = 32'h0000_0040;
            pushExp($sformatf("busy15_%0d", i), BUSY, ALL, 32'h0, 2'b00);
        end
        @(negedge clk); idleInputs(); pushExp("noTimeout", NORMAL, ALL, 32'h0, 2'b00);

        // 16 busy cycles: timeout; pending ex_invalid on the last one is discarded
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); mem_busy = 1'b1; mem_pc = 32'h0000_0040;
            if (i == 15) begin
                ex_invalid = 1'b1; ex_pc = 32'h0000_0099; ex_cause = 1'b1;
            end
            pushExp($sformatf("busy16_%0d", i), BUSY, ALL, 32'h0, 2'b00);
        end
        @(negedge clk); mem_busy = 1'b0;
        ex_mem_read = 1'b1; ex_rd_load = 3'd2; id_rs1 = 3'd2; id_use_rs1 = 1'b1;
        pushExp("toFlush0", FLUSH, FLUSH_M, 32'h40, 2'b10);
        @(negedge clk); idleInputs(); mem_busy = 1'b1;
        pushExp("toFlush1", FLUSH, FLUSH_M, 32'h40, 2'b10);
        @(negedge clk); idleInputs(); pushExp("toRedir", REDIRECT, REDIRECT_M, 32'h40, 2'b10);
        checkVal("handlerPc", handler_pc, 32'h0000_0080);
        @(negedge clk); pushExp("toRun", NORMAL, ALL, 32'h40, 2'b10);

        // Invalid opcode, cause code 1
        @(negedge clk); ex_invalid = 1'b1; ex_cause = 1'b1; ex_pc = 32'h0000_001C;
        pushExp("inv1", INVALID, INVALID_M, 32'h40, 2'b10);
        @(negedge clk); idleInputs(); pushExp("inv1Fl0", FLUSH, FLUSH_M, 32'h1C, 2'b11);
        @(negedge clk); pushExp("inv1Fl1", FLUSH, FLUSH_M, 32'h1C, 2'b11);
        @(negedge clk); pushExp("inv1Redir", REDIRECT, REDIRECT_M, 32'h1C, 2'b11);
        @(negedge clk); pushExp("inv1Run", NORMAL, ALL, 32'h1C, 2'b11);

        // Invalid with cause code 0 beats a simultaneous load-use
        @(negedge clk); ex_invalid = 1'b1; ex_cause = 1'b0; ex_pc = 32'h0000_0020;
        ex_mem_read = 1'b1; ex_rd_load = 3'd4; id_rs2 = 3'd4; id_use_rs2 = 1'b1;
        pushExp("inv0", INVALID, INVALID_M, 32'h1C, 2'b11);
        @(negedge clk); idleInputs(); pushExp("inv0Fl0", FLUSH, FLUSH_M, 32'h20, 2'b01);
        @(negedge clk); pushExp("inv0Fl1", FLUSH, FLUSH_M, 32'h20, 2'b01);
        @(negedge clk); pushExp("inv0Redir", REDIRECT, REDIRECT_M, 32'h20, 2'b01);
        @(negedge clk); pushExp("inv0Run", NORMAL, ALL, 32'h20, 2'b01);

        // Reset dropped during the first flush cycle
        @(negedge clk); ex_invalid = 1'b1; ex_cause = 1'b1; ex_pc = 32'h0000_0024;
        pushExp("inv2", INVALID, INVALID_M, 32'h20, 2'b01);
        @(negedge clk); idleInputs(); reset = 1'b0;
        pushExp("rstMid", RESET_V, ALL, 32'h0, 2'b00);
        @(negedge clk); reset = 1'b1; pushExp("rstRel", NORMAL, ALL, 32'h0, 2'b00);
        @(negedge clk); pushExp("rstRun", NORMAL, ALL, 32'h0, 2'b00);

        @(negedge clk);
        @(negedge clk);
        checkVal("sbDrain", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
